lab5_ifetch_queue: RTL and testbench
====================================

// Module: lab5_ifetch_queue
// PURPOSE
//  Instruction fetch front end; the requester side of the 16-bit instruction memory port.
//  Drives byte address IADDR and samples 16-bit IDATA. The memory returns IDATA
//  combinationally in the same cycle, using word index IADDR[7:1].
//  Pushes {pc, instr} into a small queue and presents it to decode with a valid/ready handshake.
//  Supports decode backpressure, branch/jump redirect with flush, and a fetch enable.
// PARAMETERS
//  ADDR_W   8    byte-address / PC width
//  DATA_W   16   instruction width
//  DEPTH    2    queue entries (power of 2, >=2)
//  RESET_PC 0    PC loaded at reset (bit 0 forced 0)
// PORTS
//  CLK          in   1       rising-edge clock
//  RESET_N      in   1       asynchronous, active-low reset
//  IADDR        out  ADDR_W  byte address to instruction memory (= PC register)
//  IDATA        in   DATA_W  instruction word at IADDR, same cycle
//  FETCH_EN     in   1       1 = fetch allowed this cycle
//  REDIRECT     in   1       1 = flush queue and load PC from REDIRECT_PC
//  REDIRECT_PC  in   ADDR_W  redirect target; bit 0 ignored (treated as 0)
//  INSTR_VALID  out  1       queue head valid
//  INSTR_READY  in   1       decode accepts head this cycle
//  INSTR        out  DATA_W  head instruction
//  INSTR_PC     out  ADDR_W  byte address of head instruction
// BEHAVIOUR
//  Reset (RESET_N=0, takes effect immediately, no clock needed):
//   - PC=IADDR=RESET_PC, queue count=0, INSTR_VALID=0, INSTR=0, INSTR_PC=0.
//  Definitions:
//   - pop  = INSTR_VALID & INSTR_READY
//   - push = FETCH_EN & ~REDIRECT & (count<DEPTH | pop)
//  On push:
//   - entry {IADDR, IDATA} written at tail.
//   - PC <= PC+2, modulo 2^ADDR_W, so 0xFE wraps to 0x00.
//  Without push (and without redirect), PC holds; IADDR is stable and never advances unfetched.
//  On pop: head advances. Simultaneous push+pop while full keeps count = DEPTH with no loss.
//  Outputs:
//   - INSTR_VALID = (count != 0). INSTR and INSTR_PC show the head.
//   - INSTR and INSTR_PC are stable while VALID=1 and READY=0.
//  Latency: an instruction fetched in cycle N is visible at INSTR in cycle N+1.
//  REDIRECT (priority over everything):
//   - count <= 0 and PC <= {REDIRECT_PC[ADDR_W-1:1],1'b0}. No push that cycle.
//   - A pop in the same cycle is acknowledged, then discarded by the flush.
//   - Next cycle: fetch from the target. The cycle after: INSTR_VALID=1 with INSTR_PC = target.
//   - Redirect-to-valid latency is 2 cycles.
//   - Back-to-back redirects: the last one wins.
//  FETCH_EN=0: no push. Queue still drains via pop.
//  Width rules: all PC arithmetic is ADDR_W bits, unsigned, wrap-around. No overflow flag.
//  Queue pointers are log2(DEPTH) bits and wrap. Count is log2(DEPTH)+1 bits.
//  Never push when full without a pop. Never pop when empty (INSTR_VALID=0 blocks it).
// TESTING
//  1 Reset, then FETCH_EN=1, READY=1, memory word0=0xF001, word1=0x517F.
//    -> IADDR 0,2,4,...; cycle 1 INSTR=0xF001/PC 0x00; cycle 2 INSTR=0x517F/PC 0x02.
//  2 Stream as in 1, then READY=0 for 5 cycles.
//    -> count saturates at 2 and IADDR holds. On READY=1, INSTR_PC sequence continues
//       contiguously with no duplicate or skip.
//  3 REDIRECT=1 with REDIRECT_PC=0x13, word9=0xF32D.
//    -> next cycle VALID=0 and IADDR=0x12; following cycle INSTR=0xF32D, INSTR_PC=0x12.
//  4 REDIRECT to 0xFE with READY=1.
//    -> INSTR_PC sequence 0xFE then 0x00; no glitch in VALID.
//  5 REDIRECT and pop in the same cycle with the queue full.
//    -> flushed; the next valid head has INSTR_PC = target. FETCH_EN=0 holds IADDR while
//       the queue drains to empty.
//  6 RESET_N low mid-stream between clock edges.
//    -> INSTR_VALID=0 and IADDR=RESET_PC immediately. After release, behaves as scenario 1.

Source files
------------

// File: rtl/lab5_ifetch_queue.sv
// Instruction fetch front end: drives the instruction memory address, queues {pc, instr}
// pairs and hands them to decode over a valid/ready handshake, with redirect/flush support.
module lab5_ifetch_queue #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  output logic [ADDR_W-1:0] IADDR,
  input  logic [DATA_W-1:0] IDATA,
  input  logic              FETCH_EN,
  input  logic              REDIRECT,
  input  logic [ADDR_W-1:0] REDIRECT_PC,
  output logic              INSTR_VALID,
  input  logic              INSTR_READY,
  output logic [DATA_W-1:0] INSTR,
  output logic [ADDR_W-1:0] INSTR_PC
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] HALF_MSK = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_INIT  = RESET_PC & HALF_MSK;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  entry_t             q_mem [DEPTH];
  entry_t             head_entry;
  logic [ADDR_W-1:0]  pc;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               pop;
  logic               push;

  assign IADDR       = pc;
  assign INSTR_VALID = (count != '0);
  assign pop         = INSTR_VALID & INSTR_READY;
  // A pop frees a slot in the same cycle, so a full queue can still accept a fetch.
  assign push        = FETCH_EN & ~REDIRECT & ((count < FULL_CNT) | pop);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc    <= PC_INIT;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (REDIRECT) begin
      // A pop acknowledged this cycle is simply dropped along with the rest of the queue.
      pc    <= REDIRECT_PC & HALF_MSK;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc   <= pc + ADDR_W'(2);
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: queue storage has no reset; its contents only matter once count marks
  // them valid, and the outputs are masked to zero while the queue is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_mem[tail] <= '{pc: pc, instr: IDATA};
    end
  end

  assign head_entry = q_mem[head];
  assign INSTR      = INSTR_VALID ? head_entry.instr : '0;
  assign INSTR_PC   = INSTR_VALID ? head_entry.pc    : '0;

endmodule

// File: tb/tb_lab5_ifetch_queue.sv
// Directed bench for lab5_ifetch_queue with a combinational instruction memory model.
module tb_lab5_ifetch_queue;

  logic        CLK;
  logic        RESET_N;
  logic [7:0]  IADDR;
  logic [15:0] IDATA;
  logic        FETCH_EN;
  logic        REDIRECT;
  logic [7:0]  REDIRECT_PC;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [15:0] INSTR;
  logic [7:0]  INSTR_PC;

  logic [15:0] imem [128];
  int          vectors     = 0;
  int          miscompares = 0;

  lab5_ifetch_queue dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .IADDR       (IADDR),
    .IDATA       (IDATA),
    .FETCH_EN    (FETCH_EN),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .INSTR       (INSTR),
    .INSTR_PC    (INSTR_PC)
  );

  assign IDATA = imem[IADDR[7:1]];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Checks the fetch address and the queue head; instruction comes from the memory model.
  task automatic expect_state(input string tag, input logic v, input logic [7:0] hpc,
                              input logic [7:0] iaddr_exp);
    logic [15:0] word;
    check({tag, ".IADDR"}, 32'(IADDR), 32'(iaddr_exp));
    check({tag, ".VALID"}, 32'(INSTR_VALID), 32'(v));
    if (v) begin
      word = imem[hpc[7:1]];
      check({tag, ".INSTR_PC"}, 32'(INSTR_PC), 32'(hpc));
      check({tag, ".INSTR"}, 32'(INSTR), 32'(word));
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = 16'hA000 | 16'(i);
    imem[0]   = 16'hF001;
    imem[1]   = 16'h517F;
    imem[9]   = 16'hF32D;
    imem[127] = 16'hC0DE;

    RESET_N     = 1'b0;
    FETCH_EN    = 1'b0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = 8'h00;
    INSTR_READY = 1'b0;

    // Reset state, before any clock edge.
    #3;
    check("rst.IADDR", 32'(IADDR), 32'h00);
    check("rst.VALID", 32'(INSTR_VALID), 32'h0);
    check("rst.INSTR", 32'(INSTR), 32'h0);
    check("rst.INSTR_PC", 32'(INSTR_PC), 32'h00);

    // 1: stream from word 0.
    #9;
    RESET_N     = 1'b1;
    FETCH_EN    = 1'b1;
    INSTR_READY = 1'b1;
    step(); expect_state("s1.c1", 1'b1, 8'h00, 8'h02);
    check("s1.c1.word0", 32'(INSTR), 32'hF001);
    step(); expect_state("s1.c2", 1'b1, 8'h02, 8'h04);
    check("s1.c2.word1", 32'(INSTR), 32'h517F);
    step(); expect_state("s1.c3", 1'b1, 8'h04, 8'h06);

    // 2: backpressure; queue fills to 2, then IADDR holds with a stable head.
    INSTR_READY = 1'b0;
    step(); expect_state("s2.bp1", 1'b1, 8'h04, 8'h08);
    step(); expect_state("s2.bp2", 1'b1, 8'h04, 8'h08);
    step(); expect_state("s2.bp3", 1'b1, 8'h04, 8'h08);
    step(); expect_state("s2.bp4", 1'b1, 8'h04, 8'h08);
    step(); expect_state("s2.bp5", 1'b1, 8'h04, 8'h08);
    INSTR_READY = 1'b1;
    step(); expect_state("s2.rel1", 1'b1, 8'h06, 8'h0A);
    step(); expect_state("s2.rel2", 1'b1, 8'h08, 8'h0C);
    step(); expect_state("s2.rel3", 1'b1, 8'h0A, 8'h0E);

    // 3: redirect to an odd target; bit 0 is dropped.
    REDIRECT    = 1'b1;
    REDIRECT_PC = 8'h13;
    step(); expect_state("s3.flush", 1'b0, 8'h00, 8'h12);
    REDIRECT    = 1'b0;
    step(); expect_state("s3.tgt", 1'b1, 8'h12, 8'h14);
    check("s3.tgt.word9", 32'(INSTR), 32'hF32D);

    // 4: redirect to the top of the address space; PC wraps to 0.
    REDIRECT    = 1'b1;
    REDIRECT_PC = 8'hFE;
    step(); expect_state("s4.flush", 1'b0, 8'h00, 8'hFE);
    REDIRECT    = 1'b0;
    step(); expect_state("s4.fe", 1'b1, 8'hFE, 8'h00);
    step(); expect_state("s4.wrap", 1'b1, 8'h00, 8'h02);

    // 5: fill the queue, then redirect with a simultaneous pop.
    INSTR_READY = 1'b0;
    step(); expect_state("s5.fill", 1'b1, 8'h00, 8'h04);
    step(); expect_state("s5.full", 1'b1, 8'h00, 8'h04);
    INSTR_READY = 1'b1;
    REDIRECT    = 1'b1;
    REDIRECT_PC = 8'h40;
    step(); expect_state("s5.flush", 1'b0, 8'h00, 8'h40);
    REDIRECT    = 1'b0;
    INSTR_READY = 1'b0;
    step(); expect_state("s5.tgt", 1'b1, 8'h40, 8'h42);
    step(); expect_state("s5.fill2", 1'b1, 8'h40, 8'h44);
    FETCH_EN    = 1'b0;
    INSTR_READY = 1'b1;
    step(); expect_state("s5.drain1", 1'b1, 8'h42, 8'h44);
    step(); expect_state("s5.drain2", 1'b0, 8'h00, 8'h44);
    step(); expect_state("s5.idle", 1'b0, 8'h00, 8'h44);

    // 6: asynchronous reset mid-cycle, then a clean restart.
    FETCH_EN = 1'b1;
    step(); expect_state("s6.run", 1'b1, 8'h44, 8'h46);
    #3;
    RESET_N = 1'b0;
    #1;
    check("s6.rst.VALID", 32'(INSTR_VALID), 32'h0);
    check("s6.rst.IADDR", 32'(IADDR), 32'h00);
    check("s6.rst.INSTR", 32'(INSTR), 32'h0);
    check("s6.rst.INSTR_PC", 32'(INSTR_PC), 32'h00);
    step(); expect_state("s6.held", 1'b0, 8'h00, 8'h00);
    #2;
    RESET_N = 1'b1;
    step(); expect_state("s6.c1", 1'b1, 8'h00, 8'h02);
    check("s6.c1.word0", 32'(INSTR), 32'hF001);
    step(); expect_state("s6.c2", 1'b1, 8'h02, 8'h04);
    check("s6.c2.word1", 32'(INSTR), 32'h517F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
